operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Issue-side reader of the 32x64 integer register file. It drives the RF read addresses and captures src1/src2, with bypass from writeback.
- Keeps a busy-bit scoreboard of in-flight destination registers and stalls on RAW/WAW hazards.
- Presents operands to execute through a single registered valid/ready stage.
- Sits between decode and execute. Writeback drives the RF write port and this block's wb_* inputs in parallel.

Parameters:
XLEN, 64, data width of registers and operands
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register address width, equals log2(NREG)
CNTW, 32, width of stall performance counter

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decode offers an instruction
in_ready  output  1  block accepts offer this cycle
in_rs1  input  AW  source register 1
in_rs2  input  AW  source register 2
in_rd  input  AW  destination register
in_rd_wen  input  1  instruction writes in_rd
rf_rs1  output  AW  RF read address 1, equals in_rs1 (combinational)
rf_rs2  output  AW  RF read address 2, equals in_rs2 (combinational)
rf_src1  input  XLEN  RF combinational read data 1
rf_src2  input  XLEN  RF combinational read data 2
wb_valid  input  1  writeback retires a register write this cycle
wb_addr  input  AW  writeback destination
wb_data  input  XLEN  writeback data
out_valid  output  1  operands held for execute
out_ready  input  1  execute consumes held operands
out_src1  output  XLEN  operand 1
out_src2  output  XLEN  operand 2
out_rd  output  AW  destination passthrough
out_rd_wen  output  1  write-enable passthrough
flush  input  1  discard held instruction and clear scoreboard
stall_cnt  output  CNTW  cycles with in_valid high and a hazard present

Behaviour:
- Reset (async): out_valid=0, out_src1/2=0, out_rd=0, out_rd_wen=0, busy[31:0]=0, stall_cnt=0.
- Register index 0:
  - busy[0] is never set.
  - Reads of x0 yield 0 regardless of rf_src or bypass.
- clr_k: wb_valid && wb_addr==k.
- Effective busy: ebusy[k] = busy[k] && !clr_k. Writeback clears the bit in the same cycle.
- Hazards:
  - RAW: (in_rs1!=0 && ebusy[in_rs1]) || (in_rs2!=0 && ebusy[in_rs2]).
  - WAW: in_rd_wen && in_rd!=0 && ebusy[in_rd].
  - hazard = RAW || WAW.
- Stage handshake:
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && !hazard && !flush.
  - accept = in_valid && in_ready.
- Operand select, per source: 0 if rs==0; else wb_data if wb_valid && wb_addr==rs; else rf_src.
- On accept, next edge:
  - out_src1/2, out_rd, out_rd_wen load.
  - out_valid=1.
  - busy[in_rd] set if in_rd_wen && in_rd!=0.
- Consume without accept: out_valid && out_ready && !accept -> out_valid=0 next edge. Held data is not required to change.
- Scoreboard update order each edge: clear busy[wb_addr] on wb_valid, then set from accept. Set wins on the same index.
- Latency: accept to out_valid is 1 cycle. Back-to-back independent accepts sustain 1 instruction/cycle when out_ready=1.
- Hold rule: out_* are stable while out_valid && !out_ready.
- flush:
  - Next edge: out_valid=0, all busy=0. No accept that cycle. stall_cnt unaffected.
  - Flush is asserted only when no writebacks other than the held instruction are outstanding (pipeline contract).
- stall_cnt:
  - Increments by 1 each cycle in_valid && hazard && !flush.
  - Wraps modulo 2^CNTW. Structural stalls (slot not free) are not counted.
- wb_valid for a register whose busy bit is 0 is legal and has no effect on busy.

Decomposition:
- Shared package holds:
  - XLEN, NREG, AW constants.
  - Type reg_addr_t (AW bits) and xword_t (XLEN bits).
  - Struct issue_op_t {src1, src2, rd, rd_wen} used as the output-stage payload.
- One natural sub-module: operand_scoreboard.
  - Holds busy vector, set/clear ports, and RAW/WAW hazard compare.
  - Top holds the bypass mux, output register, handshake and counter.

Test Plan:
- Reset mid-operation with out_valid=1 and busy[5]=1 -> outputs and busy return to 0 immediately (async), stall_cnt=0.
- Independent stream, out_ready=1:
  - Issue rd=1, then rd=2 with rs1=3 (rf_src1=0xAA) -> in_ready held 1.
  - out_src1=0xAA one cycle after accept, throughput 1/cycle.
- RAW stall then bypass:
  - Issue rd=5, then rs1=5 -> in_ready=0 and stall_cnt increments per cycle.
  - Assert wb_valid, wb_addr=5, wb_data=0x1234 -> accepted that cycle, out_src1=0x1234 next cycle.
- Same-cycle clear and set: with busy[7]=1, wb_addr=7 coincides with accepting rd=7 -> busy[7]=1 after the edge; a following rs1=7 stalls.
- x0 handling: rd=0, rd_wen=1 never sets busy; rs1=0 with rf_src1=0xFFFF and wb_valid, wb_addr=0 -> out_src1=0.
- Backpressure and flush:
  - out_ready=0 for 3 cycles -> out_* stable and in_ready=0.
  - flush -> out_valid=0 and busy all 0 next cycle, with no accept during flush.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage and its scoreboard.
package operand_fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  typedef struct packed {
    xword_t    src1;
    xword_t    src2;
    reg_addr_t rd;
    logic      rd_wen;
  } issue_op_t;

  // x0 reads as zero; a same-cycle writeback to the source wins over the RF.
  function automatic xword_t select_operand(input reg_addr_t rs, input xword_t rf,
                                            input logic wbv, input reg_addr_t wba,
                                            input xword_t wbd);
    if (rs == '0)
      return '0;
    else if (wbv && wba == rs)
      return wbd;
    else
      return rf;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy-bit scoreboard of in-flight destinations with RAW/WAW hazard detection.
module operand_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      flush,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  input  reg_addr_t rd,
  input  logic      rd_wen,
  output logic      hazard
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] ebusy;
  logic [NREG-1:0] busy_nxt;
  logic            raw;
  logic            waw;

  // A writeback retiring this cycle already hides its busy bit from hazard checks.
  always_comb begin
    ebusy = '0;
    for (int unsigned k = 0; k < NREG; k++)
      ebusy[k] = busy[k] && !(clr_en && clr_addr == reg_addr_t'(k));
  end

  always_comb begin
    raw    = (rs1 != '0 && ebusy[rs1]) || (rs2 != '0 && ebusy[rs2]);
    waw    = rd_wen && rd != '0 && ebusy[rd];
    hazard = raw || waw;
  end

  // Clear first, then set, so a new producer of the same register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en)
      busy_nxt[clr_addr] = 1'b0;
    if (set_en)
      busy_nxt[set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      busy <= '0;
    else if (flush)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: RF read with writeback bypass, hazard stall, one registered output stage.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned CNTW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic [AW-1:0]   in_rd,
  input  logic            in_rd_wen,
  output logic [AW-1:0]   rf_rs1,
  output logic [AW-1:0]   rf_rs2,
  input  logic [XLEN-1:0] rf_src1,
  input  logic [XLEN-1:0] rf_src2,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wen,
  input  logic            flush,
  output logic [CNTW-1:0] stall_cnt
);

  logic      hazard;
  logic      slot_free;
  logic      accept;
  issue_op_t next_op;
  issue_op_t held;

  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;

  operand_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .set_en   (accept && in_rd_wen && in_rd != '0),
    .set_addr (in_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .rd       (in_rd),
    .rd_wen   (in_rd_wen),
    .hazard   (hazard)
  );

  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = slot_free && !hazard && !flush;
    accept    = in_valid && in_ready;
    next_op.src1   = select_operand(in_rs1, rf_src1, wb_valid, wb_addr, wb_data);
    next_op.src2   = select_operand(in_rs2, rf_src2, wb_valid, wb_addr, wb_data);
    next_op.rd     = in_rd;
    next_op.rd_wen = in_rd_wen;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= next_op;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (in_valid && hazard && !flush)
      stall_cnt <= stall_cnt + CNTW'(1);
  end

  assign out_src1   = held.src1;
  assign out_src2   = held.src2;
  assign out_rd     = held.rd;
  assign out_rd_wen = held.rd_wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch with hand-written multi-cycle sequences.
module tb_operand_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_wen;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [63:0] rf_src1, rf_src2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_src1, out_src2;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic        flush;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  operand_fetch #(.CNTW(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_src1(rf_src1), .rf_src2(rf_src2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        wen;
    logic [63:0] rf1, rf2;
    logic        wbv;
    logic [4:0]  wba;
    logic [63:0] wbd;
    logic        ordy, fl;
    logic        eir, eov;
    logic [63:0] es1, es2;
    logic [4:0]  erd;
    logic        ewen;
    logic [31:0] est;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [63:0] rf1,
                       input logic [63:0] rf2, input logic wbv, input logic [4:0] wba,
                       input logic [63:0] wbd, input logic ordy, input logic fl);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_wen = wen;
    rf_src1 = rf1; rf_src2 = rf2; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    out_ready = ordy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // v rs1 rs2 rd wen rf1 rf2 wbv wba wbd ordy fl | ir ov s1 s2 rd wen stall
    vecs[0]  = '{1, 0, 0, 1, 1, 64'h0,  64'h0,  0, 0, 64'h0,    1, 0, 1, 1, 64'h0,    64'h0,    1, 1, 0};
    vecs[1]  = '{1, 3, 4, 2, 1, 64'hAA, 64'hBB, 0, 0, 64'h0,    1, 0, 1, 1, 64'hAA,   64'hBB,   2, 1, 0};
    vecs[2]  = '{1, 6, 0, 5, 1, 64'h11, 64'h22, 0, 0, 64'h0,    1, 0, 1, 1, 64'h11,   64'h0,    5, 1, 0};
    vecs[3]  = '{1, 5, 0, 8, 1, 64'h77, 64'h0,  0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    64'h0,    0, 0, 1};
    vecs[4]  = '{1, 5, 0, 8, 1, 64'h77, 64'h0,  0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    64'h0,    0, 0, 2};
    vecs[5]  = '{1, 5, 0, 8, 1, 64'h77, 64'h0,  1, 5, 64'h1234, 1, 0, 1, 1, 64'h1234, 64'h0,    8, 1, 2};
    vecs[6]  = '{1, 0, 0, 0, 1, 64'hFFFF, 64'hFFFF, 1, 0, 64'h5555, 1, 0, 1, 1, 64'h0, 64'h0,  0, 1, 2};
    vecs[7]  = '{1, 3, 3, 2, 1, 64'h0,  64'h0,  0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    64'h0,    0, 0, 3};
    vecs[8]  = '{1, 3, 4, 2, 0, 64'hC,  64'hD,  0, 0, 64'h0,    1, 0, 1, 1, 64'hC,    64'hD,    2, 0, 3};
    vecs[9]  = '{1, 0, 0, 8, 1, 64'h0,  64'h0,  1, 8, 64'h99,   1, 0, 1, 1, 64'h0,    64'h0,    8, 1, 3};
    vecs[10] = '{1, 8, 0, 10, 1, 64'h0, 64'h0,  0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    64'h0,    0, 0, 4};
    vecs[11] = '{0, 0, 0, 0, 0, 64'h0,  64'h0,  1, 8, 64'h99,   1, 0, 1, 0, 64'h0,    64'h0,    0, 0, 4};
    vecs[12] = '{1, 20, 0, 3, 1, 64'h42, 64'h0, 1, 20, 64'hDEAD, 1, 0, 1, 1, 64'hDEAD, 64'h0,   3, 1, 4};
    vecs[13] = '{1, 0, 2, 4, 0, 64'h0,  64'h0,  1, 2, 64'h2222, 1, 0, 1, 1, 64'h0,    64'h2222, 4, 0, 4};
    vecs[14] = '{0, 1, 0, 0, 0, 64'h0,  64'h0,  0, 0, 64'h0,    1, 0, 0, 0, 64'h0,    64'h0,    0, 0, 4};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #12;
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_src1", out_src1, 64'h0);
    chk("reset_stall", 64'(stall_cnt), 64'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen, vecs[i].rf1,
            vecs[i].rf2, vecs[i].wbv, vecs[i].wba, vecs[i].wbd, vecs[i].ordy, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].eir));
      chk($sformatf("v%0d_rf_rs1", i), 64'(rf_rs1), 64'(vecs[i].rs1));
      tick();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].eov));
      chk($sformatf("v%0d_stall", i), 64'(stall_cnt), 64'(vecs[i].est));
      if (vecs[i].eov) begin
        chk($sformatf("v%0d_src1", i), out_src1, vecs[i].es1);
        chk($sformatf("v%0d_src2", i), out_src2, vecs[i].es2);
        chk($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].erd));
        chk($sformatf("v%0d_rd_wen", i), 64'(out_rd_wen), 64'(vecs[i].ewen));
      end
    end

    // Backpressure: busy now {1,3}; accept rd=6, then hold with out_ready low.
    drive(1, 0, 0, 6, 1, 64'h0, 64'h0, 0, 0, 64'h0, 1, 0);
    tick();
    chk("bp_load_valid", 64'(out_valid), 64'h1);
    chk("bp_load_rd", 64'(out_rd), 64'h6);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 7, 1, 64'h5, 64'h5, 0, 0, 64'h0, 0, 0);
      #1;
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'h0);
      tick();
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'h1);
      chk($sformatf("bp%0d_rd", c), 64'(out_rd), 64'h6);
      chk($sformatf("bp%0d_src1", c), out_src1, 64'h0);
      chk($sformatf("bp%0d_stall", c), 64'(stall_cnt), 64'h4);
    end

    // Flush with an instruction offered: nothing accepted, scoreboard cleared.
    drive(1, 0, 0, 7, 1, 64'h5, 64'h5, 0, 0, 64'h0, 0, 1);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_stall", 64'(stall_cnt), 64'h4);
    drive(1, 1, 3, 6, 1, 64'h31, 64'h33, 0, 0, 64'h0, 1, 0);
    #1;
    chk("post_flush_in_ready", 64'(in_ready), 64'h1);
    tick();
    chk("post_flush_src1", out_src1, 64'h31);
    chk("post_flush_src2", out_src2, 64'h33);

    // Set busy[5], then reset asynchronously mid-cycle.
    drive(1, 0, 0, 5, 1, 64'h0, 64'h0, 0, 0, 64'h0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'h0);
    chk("async_reset_rd", 64'(out_rd), 64'h0);
    chk("async_reset_wen", 64'(out_rd_wen), 64'h0);
    chk("async_reset_src1", out_src1, 64'h0);
    chk("async_reset_stall", 64'(stall_cnt), 64'h0);
    #1;
    reset = 1'b0;
    drive(1, 5, 6, 5, 1, 64'h50, 64'h60, 0, 0, 64'h0, 1, 0);
    #1;
    chk("after_reset_busy_clear", 64'(in_ready), 64'h1);
    tick();
    chk("after_reset_src1", out_src1, 64'h50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
